// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR flip-flops with elaboration-time conflict policy and conflict reporting.
// Optional two-sample input filter: define SR_FF_BANK_FILTER_EN.
module sr_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter int               MODE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             conflict,
  output logic [WIDTH-1:0] conflict_bits,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Out-of-range MODE values fall back to hold.
  localparam int MODE_EFF = (MODE > 3 || MODE < 0) ? 0 : MODE;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] r_eff;
  logic [WIDTH-1:0] conf;
  logic [WIDTH-1:0] set_only;
  logic [WIDTH-1:0] rst_only;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] next_q;

`ifdef SR_FF_BANK_FILTER_EN
  logic [WIDTH-1:0] hist_s;
  logic [WIDTH-1:0] hist_r;

  // A request counts only when seen on two consecutive enabled samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_s <= '0;
      hist_r <= '0;
    end else if (en) begin
      hist_s <= s;
      hist_r <= r;
    end
  end

  assign s_eff = s & hist_s;
  assign r_eff = r & hist_r;
`else
  assign s_eff = s;
  assign r_eff = r;
`endif

  assign conf     = s_eff & r_eff;
  assign set_only = s_eff & ~r_eff;
  assign rst_only = r_eff & ~s_eff;
  assign base_q   = (q | set_only) & ~rst_only;

  always_comb begin
    next_q = base_q;
    case (MODE_EFF)
      1:       next_q = base_q | conf;
      2:       next_q = base_q & ~conf;
      3:       next_q = base_q ^ conf;
      default: next_q = base_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q             <= RESET_VAL;
      conflict      <= 1'b0;
      conflict_bits <= '0;
    end else if (en) begin
      q             <= next_q;
      conflict      <= |conf;
      conflict_bits <= conf;
    end else begin
      conflict      <= 1'b0;
      conflict_bits <= '0;
    end
  end

  // Clear has priority over a same-cycle conflict; the counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_sticky <= 1'b0;
      conflict_cnt    <= '0;
    end else if (clr_cnt) begin
      conflict_sticky <= 1'b0;
      conflict_cnt    <= '0;
    end else if (en && |conf) begin
      conflict_sticky <= 1'b1;
      if (conflict_cnt != CNT_MAX) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: five instances (MODE 0..3 and out-of-range 7) share one stimulus stream.
// Instances 0..3 use CNT_W=2 to reach saturation; instance 4 uses CNT_W=8.
module tb_sr_ff_bank;

  localparam int N = 5;
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [7:0] s;
  logic [7:0] r;
  logic clr_cnt;

  logic [7:0] q_a      [N];
  logic [7:0] qbar_a   [N];
  logic       conf_a   [N];
  logic [7:0] bits_a   [N];
  logic       sticky_a [N];
  logic [7:0] cnt_a    [N];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int M  = (gi == 4) ? 7 : gi;
    localparam int CW = (gi == 4) ? 8 : 2;
    logic [CW-1:0] cnt_w;
    sr_ff_bank #(.WIDTH(8), .MODE(M), .RESET_VAL(RV), .CNT_W(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .s(s),
      .r(r),
      .clr_cnt(clr_cnt),
      .q(q_a[gi]),
      .qbar(qbar_a[gi]),
      .conflict(conf_a[gi]),
      .conflict_bits(bits_a[gi]),
      .conflict_sticky(sticky_a[gi]),
      .conflict_cnt(cnt_w)
    );
    assign cnt_a[gi] = 8'(cnt_w);
  end

  task automatic applyStimulus(input logic e, input logic [7:0] sv, input logic [7:0] rv,
                               input logic c);
    en = e; s = sv; r = rv; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input int i, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s inst%0d: observed %h expected %h", tag, i, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int i, input logic [7:0] eq, input logic ec,
                             input logic [7:0] eb, input logic es, input logic [7:0] ecnt);
    chk8({tag, ".q"}, i, q_a[i], eq);
    chk8({tag, ".qbar"}, i, qbar_a[i], ~eq);
    chk8({tag, ".conflict"}, i, {7'd0, conf_a[i]}, {7'd0, ec});
    chk8({tag, ".bits"}, i, bits_a[i], eb);
    chk8({tag, ".sticky"}, i, {7'd0, sticky_a[i]}, {7'd0, es});
    chk8({tag, ".cnt"}, i, cnt_a[i], ecnt);
  endtask

  task automatic checkAll(input string tag, input logic [7:0] eq, input logic ec,
                          input logic [7:0] eb, input logic es, input logic [7:0] ecnt);
    for (int i = 0; i < N; i++) checkOutput(tag, i, eq, ec, eb, es, ecnt);
  endtask

  logic [7:0] exp_q    [N];
  logic [7:0] exp_cnt  [N];

  initial begin
    rst_n = 1'b0; en = 1'b1; s = '0; r = '0; clr_cnt = 1'b0;
    #12;
    checkAll("reset", RV, 1'b0, 8'h00, 1'b0, 8'd0);
    rst_n = 1'b1;

    // Idle after release
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
      checkAll("idle", RV, 1'b0, 8'h00, 1'b0, 8'd0);
    end

    // Basic set/reset
    applyStimulus(1'b1, 8'h00, 8'hFF, 1'b0);
    checkAll("clear_q", 8'h00, 1'b0, 8'h00, 1'b0, 8'd0);
    applyStimulus(1'b1, 8'h0F, 8'h00, 1'b0);
    checkAll("set_0f", 8'h0F, 1'b0, 8'h00, 1'b0, 8'd0);
    applyStimulus(1'b1, 8'h00, 8'h03, 1'b0);
    checkAll("rst_03", 8'h0C, 1'b0, 8'h00, 1'b0, 8'd0);

    // Conflict modes from q=F0
    applyStimulus(1'b1, 8'hF0, 8'h0F, 1'b0);
    checkAll("load_f0", 8'hF0, 1'b0, 8'h00, 1'b0, 8'd0);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0);
    exp_q = '{8'hF0, 8'hFF, 8'h00, 8'h0F, 8'hF0};
    for (int i = 0; i < N; i++) checkOutput("conf_mode", i, exp_q[i], 1'b1, 8'hFF, 1'b1, 8'd1);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < N; i++) checkOutput("conf_after", i, exp_q[i], 1'b0, 8'h00, 1'b1, 8'd1);

    // Saturation: clear first, then 5 conflicting cycles on bits 0 and 7
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < N; i++) checkOutput("clr", i, exp_q[i], 1'b0, 8'h00, 1'b0, 8'd0);
    exp_cnt = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 8'h81, 8'h81, 1'b0);
      exp_q[1] = exp_q[1] | 8'h81;
      exp_q[2] = exp_q[2] & 8'h7E;
      exp_q[3] = (k % 2 == 1) ? 8'h8E : 8'h0F;
      for (int i = 0; i < N; i++) begin
        if (i == 4) exp_cnt[i] = 8'(k);
        else        exp_cnt[i] = (k >= 3) ? 8'd3 : 8'(k);
        checkOutput("sat", i, exp_q[i], 1'b1, 8'h81, 1'b1, exp_cnt[i]);
      end
    end
    // Clear wins over simultaneous conflict
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1);
    exp_q[1] = 8'hFF; exp_q[2] = 8'h00; exp_q[3] = 8'h71;
    for (int i = 0; i < N; i++) checkOutput("clr_conf", i, exp_q[i], 1'b1, 8'hFF, 1'b0, 8'd0);

    // Enable gating
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0);
      for (int i = 0; i < N; i++) checkOutput("en_off", i, exp_q[i], 1'b0, 8'h00, 1'b0, 8'd0);
    end
    applyStimulus(1'b0, 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < N; i++) checkOutput("en_off_s", i, exp_q[i], 1'b0, 8'h00, 1'b0, 8'd0);
    applyStimulus(1'b0, 8'h00, 8'hFF, 1'b0);
    for (int i = 0; i < N; i++) checkOutput("en_off_r", i, exp_q[i], 1'b0, 8'h00, 1'b0, 8'd0);

    // Async reset mid-stream
    applyStimulus(1'b1, 8'h00, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'h01, 8'h00, 1'b0);
    checkAll("pre_rst", 8'h01, 1'b0, 8'h00, 1'b0, 8'd0);
    applyStimulus(1'b1, 8'h01, 8'h01, 1'b0);
    exp_q = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < N; i++) checkOutput("pre_rst_c", i, exp_q[i], 1'b1, 8'h01, 1'b1, 8'd1);
    s = 8'h01; r = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    checkAll("async_rst", RV, 1'b0, 8'h00, 1'b0, 8'd0);
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 8'h00, 8'h01, 1'b0);
    checkAll("post_rst", 8'hA4, 1'b0, 8'h00, 1'b0, 8'd0);
    applyStimulus(1'b1, 8'h5A, 8'h00, 1'b0);
    checkAll("post_set", 8'hFE, 1'b0, 8'h00, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout: observed no completion, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised, clocked successor to the single SR storage element: a bank of WIDTH independent SR flip-flops sharing one clock and one enable.
- Each bit is set, reset or held on the enable edge. Conflict behaviour is selected at elaboration time.
- Simultaneous S/R assertions are detected, reported and counted, so the forbidden condition is observable rather than producing X.
- Used as a status/flag register bank by control logic in the same design.

Parameters:
- WIDTH, 8, number of SR channels (1..64)
- MODE, 0, conflict resolution when s[i]&r[i]: 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle (JK behaviour); values >3 behave as 0
- RESET_VAL, 0, WIDTH-bit value loaded into q on reset
- CNT_W, 8, width of the saturating conflict counter (2..16)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  update enable; when low, the bank holds state
- s  input  WIDTH  per-channel set request
- r  input  WIDTH  per-channel reset request
- clr_cnt  input  1  synchronous clear of conflict_cnt and conflict_sticky
- q  output  WIDTH  registered state
- qbar  output  WIDTH  always ~q
- conflict  output  1  registered one-cycle pulse: at least one channel had s&r in the previous enabled cycle
- conflict_bits  output  WIDTH  registered per-channel conflict mask from the previous cycle
- conflict_sticky  output  1  set by any conflict; cleared only by reset or clr_cnt
- conflict_cnt  output  CNT_W  count of enabled cycles that contained at least one conflict; saturating

Behaviour:
- Reset (async assert, sync release): q=RESET_VAL, qbar=~RESET_VAL, conflict=0, conflict_bits=0, conflict_sticky=0, conflict_cnt=0. Reset mid-operation discards all pending updates. The first edge after deassertion is a normal cycle.
- Latency is 1 cycle: inputs sampled at edge N appear on q after edge N.
- qbar is derived from the q register, never independently stored. q and qbar are never equal and never X after reset.
- Per channel, when en=1:
  - s=0, r=0: hold.
  - s=1, r=0: q=1.
  - s=0, r=1: q=0.
  - s=1, r=1: resolved per MODE (hold / 1 / 0 / ~q).
- en=0: q holds; conflict=0 and conflict_bits=0 on the next edge; the counter does not increment, even if s&r is present.
- Conflict detection, on every enabled cycle:
  - conflict_bits <= s&r.
  - conflict <= |(s&r).
  - conflict_sticky <= conflict_sticky | |(s&r).
  - Detection is independent of MODE; MODE 3 toggles are still flagged.
- conflict_cnt increments by 1 per enabled conflicting cycle, regardless of how many bits conflict.
- conflict_cnt saturates at 2^CNT_W-1 with no wrap.
- clr_cnt=1 and a conflict in the same cycle: the clear wins. conflict_cnt=0 and conflict_sticky=0 after the edge. conflict and conflict_bits still report that cycle.
- clr_cnt does not affect q, qbar, conflict or conflict_bits.

Optional Feature:
- Macro: SR_FF_BANK_FILTER_EN.
- Defined: each channel has a 1-bit history register per input. A set or reset request takes effect only if it was also asserted on the previous enabled cycle, i.e. two consecutive enabled samples are required. Latency from first assertion becomes 2 enabled cycles. en=0 cycles neither advance nor clear the history. Reset clears the history. Conflict detection uses the filtered requests.
- Undefined: no history registers; behaviour is exactly as described above.

Test Plan:
- Reset/idle, WIDTH=8, RESET_VAL=8'hA5: hold rst_n=0, then release with s=r=0, en=1 for 5 cycles -> q=8'hA5, qbar=8'h5A, all flags and conflict_cnt=0 throughout.
- Basic set/reset, MODE=0: en=1; s=8'h0F, r=0 for 1 cycle, then s=0, r=8'h03 for 1 cycle -> q=8'h0F after first edge, 8'h0C after second; conflict never asserted.
- Conflict modes, q=8'hF0, s=r=8'hFF for 1 cycle:
  - MODE=0 -> q=8'hF0.
  - MODE=1 -> 8'hFF.
  - MODE=2 -> 8'h00.
  - MODE=3 -> 8'h0F.
  - In every mode: conflict=1 for exactly one cycle, conflict_bits=8'hFF, conflict_cnt=1, conflict_sticky=1.
- Saturation/clear, CNT_W=2: 5 consecutive conflicting cycles -> conflict_cnt reads 1,2,3,3,3. Then clr_cnt=1 together with a conflict -> conflict_cnt=0, conflict_sticky=0, conflict=1.
- Enable gating: en=0 with s=8'hFF, r=8'hFF for 3 cycles -> q unchanged, conflict=0, conflict_cnt unchanged.
- Async reset mid-stream: rst_n pulsed low between edges while s=8'h01 -> q=RESET_VAL immediately, before the next clk edge. With SR_FF_BANK_FILTER_EN, s=8'h01 for 1 cycle leaves q unchanged, and for 2 consecutive cycles sets q[0] on the second edge.
